// File: rtl/lvds_link_pkg.sv
// Shared types and helpers for the LVDS link trainer.
// Latency: n/a (types, constants and an elaboration-time function only).
// Backpressure: n/a.
package lvds_link_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_UP      = 2'd2,
    ST_HOLDOFF = 2'd3
  } link_state_e;

  // Sync-word cycles sent after a drop so the far end reliably sees the link go down.
  localparam int HOLDOFF_CYCLES = 16;

  // Upper bound on the serializer word width the sync-word builder supports.
  localparam int SYNC_MAX_W = 1024;

  // Repeats the low 'ser' bits of 'pattern' across 'chans' lanes; bits above ser*chans are zero.
  function automatic logic [SYNC_MAX_W-1:0] build_sync_word(input logic [31:0] pattern,
                                                             input int          ser,
                                                             input int          chans);
    logic [SYNC_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < SYNC_MAX_W; i++) begin
      if (i < ser * chans) w[i] = pattern[i % ser];
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, one flop pair per bit.
// Latency: 2 cycles from input change to output change.
// Backpressure: none; plain level path.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/lvds_link_trainer_tx.sv
// TX link bring-up: sends per-lane sync words until both ends lock, then padded payload; owns retrain policy.
// Latency: payload registered (1 cycle); lock edge to link up 3 cycles; i_retrain to link down 1 cycle.
// Backpressure: none; the serializer consumes a word every core cycle.
module lvds_link_trainer_tx
  import lvds_link_pkg::*;
#(
  parameter int FLIT_WIDTH         = 32,
  parameter int GATE_FOLDS         = 4,
  parameter int LVDS_SERIALIZATION = 8,
  parameter int LVDS_CHANNELS      = 17,
  parameter logic [LVDS_SERIALIZATION-1:0] SYNC_PATTERN = 8'hF0,
  parameter int MIN_SYNC_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES     = 65536,
  localparam int TX_WIDTH          = FLIT_WIDTH * GATE_FOLDS,
  localparam int LVDS_WIDTH        = LVDS_CHANNELS * LVDS_SERIALIZATION
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_local_sync,
  input  logic                  i_remote_sync,
  input  logic                  i_retrain,
  input  logic [TX_WIDTH-1:0]   i_tx_data,
  output logic [LVDS_WIDTH-1:0] o_tx_word,
  output logic                  o_link_up,
  output logic                  o_training,
  output logic                  o_timeout,
  output logic [7:0]            o_retrain_cnt
);

  localparam int SYNC_W = $clog2(MIN_SYNC_CYCLES);
  localparam int ATT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES);

  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(MIN_SYNC_CYCLES - 1);
  localparam logic [ATT_W-1:0]  ATT_LAST  = ATT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  localparam logic [LVDS_WIDTH-1:0] SYNC_WORD =
    LVDS_WIDTH'(build_sync_word(32'(SYNC_PATTERN), LVDS_SERIALIZATION, LVDS_CHANNELS));

  link_state_e           state_q, state_d;
  logic [SYNC_W-1:0]     sync_cnt_q, sync_cnt_d;
  logic [ATT_W-1:0]      att_cnt_q, att_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [7:0]            retrain_cnt_q, retrain_cnt_d;
  logic [LVDS_WIDTH-1:0] tx_word_q, tx_word_d;
  logic                  link_up_q, link_up_d;
  logic                  training_q, training_d;

  logic [1:0] locks_s;
  logic       l_s;
  logic       r_s;

  sync_2ff #(.WIDTH(2)) u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     ({i_remote_sync, i_local_sync}),
    .o_q     (locks_s)
  );

  assign l_s = locks_s[0];
  assign r_s = locks_s[1];

  // Next state, counters and the registered output values, all derived from the next state.
  always_comb begin
    state_d       = state_q;
    sync_cnt_d    = sync_cnt_q;
    att_cnt_d     = att_cnt_q;
    hold_cnt_d    = '0;
    timeout_d     = timeout_q;
    retrain_cnt_d = retrain_cnt_q;

    unique case (state_q)
      ST_SYNC: begin
        att_cnt_d = att_cnt_q + ATT_W'(1);
        if (sync_cnt_q == SYNC_LAST) begin
          state_d = ST_WAIT;
        end else begin
          sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        end
      end
      ST_WAIT: begin
        att_cnt_d = att_cnt_q + ATT_W'(1);
        // A lock arriving on the timeout cycle wins: the attempt succeeded.
        if (l_s && r_s) begin
          state_d = ST_UP;
        end else if (att_cnt_q == ATT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLDOFF;
        end
      end
      ST_UP: begin
        if (i_retrain || !l_s || !r_s) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        sync_cnt_d = '0;
        att_cnt_d  = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_SYNC;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_SYNC;
    endcase

    // Count each entry into HOLDOFF once, however many causes coincide.
    if (state_d == ST_HOLDOFF && state_q != ST_HOLDOFF && retrain_cnt_q != 8'hFF) begin
      retrain_cnt_d = retrain_cnt_q + 8'd1;
    end

    link_up_d  = (state_d == ST_UP);
    training_d = (state_d == ST_SYNC) || (state_d == ST_WAIT);
    tx_word_d  = (state_d == ST_UP) ? LVDS_WIDTH'(i_tx_data) : SYNC_WORD;
  end

  // State, counters and outputs all update together so outputs line up with the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_SYNC;
      sync_cnt_q    <= '0;
      att_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
      retrain_cnt_q <= '0;
      tx_word_q     <= SYNC_WORD;
      link_up_q     <= 1'b0;
      training_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      sync_cnt_q    <= sync_cnt_d;
      att_cnt_q     <= att_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
      retrain_cnt_q <= retrain_cnt_d;
      tx_word_q     <= tx_word_d;
      link_up_q     <= link_up_d;
      training_q    <= training_d;
    end
  end

  assign o_tx_word     = tx_word_q;
  assign o_link_up     = link_up_q;
  assign o_training    = training_q;
  assign o_timeout     = timeout_q;
  assign o_retrain_cnt = retrain_cnt_q;

endmodule

// File: tb/tb_lvds_link_trainer_tx.sv
// Directed bench for lvds_link_trainer_tx: training, payload, retrain, drop, timeout, reset, saturation.
// Latency: n/a.
// Backpressure: n/a.
module tb_lvds_link_trainer_tx;

  localparam logic [135:0] SYNC_WORD = {17{8'hF0}};

  logic         clk = 1'b0;
  logic         rst_n, local_sync, remote_sync, retrain;
  logic [127:0] tx_data;
  logic [135:0] tx_word;
  logic         link_up, training, timeout;
  logic [7:0]   rcnt;

  logic         s_rst_n, s_retrain;
  logic [127:0] s_tx_data;
  logic [135:0] s_tx_word;
  logic         s_link_up, s_training, s_timeout;
  logic [7:0]   s_rcnt;

  int           vec_cnt = 0;
  int           err_cnt = 0;
  logic [135:0] sb[$];
  logic [135:0] exp_payload;

  always #5 clk = ~clk;

  lvds_link_trainer_tx #(
    .MIN_SYNC_CYCLES (256),
    .TIMEOUT_CYCLES  (1024)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_local_sync  (local_sync),
    .i_remote_sync (remote_sync),
    .i_retrain     (retrain),
    .i_tx_data     (tx_data),
    .o_tx_word     (tx_word),
    .o_link_up     (link_up),
    .o_training    (training),
    .o_timeout     (timeout),
    .o_retrain_cnt (rcnt)
  );

  // Short-training instance so hundreds of retrains fit in a small cycle budget.
  lvds_link_trainer_tx #(
    .MIN_SYNC_CYCLES (8),
    .TIMEOUT_CYCLES  (32)
  ) u_sat (
    .i_clk         (clk),
    .i_rst_n       (s_rst_n),
    .i_local_sync  (1'b1),
    .i_remote_sync (1'b1),
    .i_retrain     (s_retrain),
    .i_tx_data     (s_tx_data),
    .o_tx_word     (s_tx_word),
    .o_link_up     (s_link_up),
    .o_training    (s_training),
    .o_timeout     (s_timeout),
    .o_retrain_cnt (s_rcnt)
  );

  task automatic check_w(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive fresh payload, remember what a payload word would be, sample 1 time unit after the edge.
  task automatic tick();
    tx_data = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back({8'h00, tx_data});
    @(posedge clk);
    #1;
    exp_payload = sb.pop_front();
  endtask

  // Ticks until link up (bounded); counts cycles spent and any non-sync word seen while down.
  task automatic wait_link(input int limit, output int cycles, output int bad);
    cycles = 0;
    bad    = 0;
    while (link_up !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
      if (link_up !== 1'b1 && tx_word !== SYNC_WORD) bad++;
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_w("payload", tx_word, exp_payload);
    end
  endtask

  initial begin
    int n;
    int bad;
    int cnt_at_254;
    int stuck;

    rst_n = 1'b0; s_rst_n = 1'b0;
    local_sync = 1'b1; remote_sync = 1'b1;
    retrain = 1'b0; s_retrain = 1'b0;
    tx_data = '0; s_tx_data = '0;

    // Reset state, released between clock edges.
    #22;
    check_w("rst_tx_word", tx_word, SYNC_WORD);
    check_n("rst_link_up", int'(link_up), 0);
    check_n("rst_training", int'(training), 1);
    check_n("rst_timeout", int'(timeout), 0);
    check_n("rst_retrain_cnt", int'(rcnt), 0);
    #1 rst_n = 1'b1;

    // Both locks high from the start: 256 sync cycles, one WAIT cycle, then payload.
    wait_link(400, n, bad);
    check_n("up_from_reset_cycles", n, 257);
    check_n("sync_word_while_down", bad, 0);
    check_w("first_payload", tx_word, exp_payload);
    check_n("training_low_in_up", int'(training), 0);
    stream(6);

    // Retrain pulse: link drops next cycle, count 1; a second pulse in HOLDOFF is ignored.
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check_n("retrain_link_down", int'(link_up), 0);
    check_n("retrain_cnt_1", int'(rcnt), 1);
    check_n("holdoff_training_low", int'(training), 0);
    check_w("holdoff_sync_word", tx_word, SYNC_WORD);
    repeat (4) tick();
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check_n("retrain_ignored_holdoff", int'(rcnt), 1);
    wait_link(400, n, bad);
    check_n("retrain_relock_cycles", n, 273 - 5);
    check_n("retrain_sync_words", bad, 0);
    stream(3);

    // Local lock drop reaches the FSM after 3 edges; a retrain on that same cycle counts once.
    local_sync = 1'b0;
    tick();
    check_n("drop_edge1_up", int'(link_up), 1);
    tick();
    check_n("drop_edge2_up", int'(link_up), 1);
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    check_n("drop_edge3_down", int'(link_up), 0);
    check_n("drop_plus_retrain_cnt", int'(rcnt), 2);
    tick();
    check_n("drop_single_count", int'(rcnt), 2);
    local_sync = 1'b1;
    wait_link(400, n, bad);
    check_n("drop_relock_cycles", n, 272);
    stream(2);

    // Remote never locks: holdoff is 16 cycles, then the attempt times out after 1024 cycles.
    remote_sync = 1'b0;
    repeat (3) tick();
    check_n("remote_drop_down", int'(link_up), 0);
    check_n("remote_drop_cnt", int'(rcnt), 3);
    repeat (15) tick();
    check_n("holdoff_cycle16_training", int'(training), 0);
    tick();
    check_n("holdoff_done_training", int'(training), 1);
    n = 0;
    while (timeout !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    check_n("timeout_cycles", n, 1024);
    check_n("timeout_retrain_cnt", int'(rcnt), 4);
    check_n("timeout_training_low", int'(training), 0);
    remote_sync = 1'b1;
    wait_link(400, n, bad);
    check_n("after_timeout_relock", n, 273);
    check_n("timeout_sticky", int'(timeout), 1);
    stream(2);

    // Asynchronous reset between edges while up.
    #3 rst_n = 1'b0;
    #1;
    check_w("async_rst_tx_word", tx_word, SYNC_WORD);
    check_n("async_rst_link_up", int'(link_up), 0);
    check_n("async_rst_training", int'(training), 1);
    check_n("async_rst_timeout", int'(timeout), 0);
    check_n("async_rst_cnt", int'(rcnt), 0);

    // Remote lock lands in the FSM exactly on the timeout cycle: link comes up, no timeout flag.
    remote_sync = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1021) tick();
    remote_sync = 1'b1;
    repeat (2) tick();
    check_n("tie_still_waiting", int'(link_up), 0);
    tick();
    check_n("tie_link_up", int'(link_up), 1);
    check_n("tie_no_timeout", int'(timeout), 0);
    check_n("tie_no_retrain", int'(rcnt), 0);

    // Retrain counter saturation on the short-training instance.
    @(posedge clk);
    #1 s_rst_n = 1'b1;
    cnt_at_254 = -1;
    stuck = 0;
    for (int i = 1; i <= 300; i++) begin
      n = 0;
      while (s_link_up !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      if (s_link_up !== 1'b1) stuck++;
      s_retrain = 1'b1;
      tick();
      s_retrain = 1'b0;
      if (i == 254) cnt_at_254 = int'(s_rcnt);
    end
    check_n("sat_no_stuck_waits", stuck, 0);
    check_n("sat_cnt_at_254", cnt_at_254, 254);
    check_n("sat_cnt_final", int'(s_rcnt), 255);
    check_n("sat_link_down", int'(s_link_up), 0);
    check_n("sat_no_timeout", int'(s_timeout), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
